gcd_engine: RTL and testbench

Parametrised successor to the single-width GCD microprocessor. It accepts two operands through the same Enter/Input strobe protocol and computes their greatest common divisor in one of two run-time selectable algorithms: repeated subtraction or binary (Stein) GCD. It reports the result on `Output` with `Halt` and flags the all-zero case. It also exposes the iteration count for performance checking, and sits wherever the old microprocessor sat, on the same bench-style handshake.

---
 rtl/gcd_engine.sv | 174 +++++++++++++++++
 tb/tb_gcd_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// gcd_engine: two-operand GCD engine with run-time selectable algorithm
// (repeated subtraction or binary/Stein GCD).
//
// Handshake: Enter is a level strobe. A load request is only its rising edge,
// rise = Enter & ~enter_q. In IDLE a rise loads X. In WAITY a rise loads Y and
// Mode, then computation starts. In DONE a rise loads a new X. A rise in CHECK,
// SUB or STEIN is dropped. Halt=1 marks Output/Error/Cycles as a valid result,
// and those values stay held until the next X load.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enter,
  input  logic [WIDTH-1:0] Input,
  input  logic             Mode,
  output logic [WIDTH-1:0] Output,
  output logic             Halt,
  output logic             Error,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Cycles
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WAITY = 4'd1,
    S_CHECK = 4'd2,
    S_SUB   = 4'd3,
    S_STEIN = 4'd4,
    S_DONE  = 4'd6
  } state_e;

  state_e           state_q, state_d;
  logic             enter_q;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic             rise;
  logic             x_gt_y;
  logic             x_eq_y;
  logic [CNT_W-1:0] cyc_inc;

  assign rise    = Enter & ~enter_q;
  assign x_gt_y  = (x_q > y_q);
  assign x_eq_y  = (x_q == y_q);
  // Saturating increment: stick at all-ones instead of wrapping.
  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    mode_d  = mode_q;
    out_d   = out_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          x_d     = Input;
          state_d = S_WAITY;
        end
      end
      S_WAITY: begin
        if (rise) begin
          y_d     = Input;
          mode_d  = Mode;
          k_d     = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cyc_d = '0;
        if ((x_q == '0) && (y_q == '0)) begin
          out_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (x_q == '0) begin
          out_d   = y_q;
          state_d = S_DONE;
        end else if (y_q == '0) begin
          out_d   = x_q;
          state_d = S_DONE;
        end else begin
          state_d = mode_q ? S_STEIN : S_SUB;
        end
      end
      S_SUB: begin
        cyc_d = cyc_inc;
        if (x_eq_y) begin
          out_d   = x_q;
          state_d = S_DONE;
        end else if (x_gt_y) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      S_STEIN: begin
        cyc_d = cyc_inc;
        if (x_eq_y) begin
          // Result <= min(X,Y) of the original operands, so the shift fits.
          out_d   = x_q << k_q;
          state_d = S_DONE;
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          // Both nonzero, so at most WIDTH-1 common halvings can occur.
          if (k_q != KW'(WIDTH - 1)) k_d = k_q + KW'(1);
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_gt_y) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      S_DONE: begin
        if (rise) begin
          x_d     = Input;
          err_d   = 1'b0;
          state_d = S_WAITY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      enter_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      enter_q <= Enter;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign Output = out_q;
  assign Error  = err_q;
  assign Cycles = cyc_q;
  assign State  = state_q;
  assign Halt   = (state_q == S_DONE);

endmodule

// File: tb/tb_gcd_engine.sv
// Testbench for gcd_engine: directed boundary cases plus random regression,
// checked against a behavioural GCD model.
module tb_gcd_engine;

  // ---------------- clock / reset ----------------
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  always #5 Clock = ~Clock;

  // 8-bit / 16-bit-counter instance
  logic        Enter = 1'b0;
  logic [7:0]  Input = '0;
  logic        Mode  = 1'b0;
  logic [7:0]  Output;
  logic        Halt, Error;
  logic [3:0]  State;
  logic [15:0] Cycles;

  // 16-bit / 4-bit-counter instance
  logic        e16 = 1'b0;
  logic [15:0] in16 = '0;
  logic        m16 = 1'b0;
  logic [15:0] out16;
  logic        h16, err16;
  logic [3:0]  st16;
  logic [3:0]  cyc16;

  gcd_engine #(.WIDTH(8), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .Input(Input), .Mode(Mode),
    .Output(Output), .Halt(Halt), .Error(Error), .State(State), .Cycles(Cycles)
  );

  gcd_engine #(.WIDTH(16), .CNT_W(4)) dut16 (
    .Clock(Clock), .Reset(Reset), .Enter(e16), .Input(in16), .Mode(m16),
    .Output(out16), .Halt(h16), .Error(err16), .State(st16), .Cycles(cyc16)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cyc_q[$];
  logic        exp_err_q[$];
  int          st_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int unsigned gcd_model(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive engine: each Euclid quotient q costs q cycles (q-1 subtractions
  // plus the final equality cycle on the last step, q subtractions otherwise).
  function automatic int unsigned sub_cycles(input int unsigned a, input int unsigned b);
    int unsigned n = 0;
    int unsigned t;
    if (a == 0 || b == 0) return 0;
    while (b != 0) begin
      n += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return n;
  endfunction

  function automatic int unsigned stein_cycles(input int unsigned a, input int unsigned b);
    int unsigned n = 0;
    if (a == 0 || b == 0) return 0;
    forever begin
      n++;
      if (a == b) break;
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
    return n;
  endfunction

  task automatic push_exp(input int unsigned x, input int unsigned y, input logic m);
    int unsigned c;
    c = m ? stein_cycles(x, y) : sub_cycles(x, y);
    if (c > 65535) c = 65535;
    exp_q.push_back(8'(gcd_model(x, y)));
    exp_cyc_q.push_back(16'(c));
    exp_err_q.push_back(x == 0 && y == 0);
  endtask

  // ---------------- compare process ----------------
  logic        halt_prev = 1'b0;
  logic        have_cur = 1'b0;
  logic [7:0]  cur_out;
  logic [15:0] cur_cyc;
  logic        cur_err;

  always @(negedge Clock) begin
    if (Reset) begin
      halt_prev = 1'b0;
      have_cur  = 1'b0;
    end else begin
      if (Halt && !halt_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_halt", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur_out  = exp_q.pop_front();
          cur_cyc  = exp_cyc_q.pop_front();
          cur_err  = exp_err_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (Halt && have_cur) begin
        check("sb_output", Output, cur_out);
        check("sb_error", Error, cur_err);
        check("sb_cycles", Cycles, cur_cyc);
      end
      halt_prev = Halt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [7:0] x, input logic [7:0] y, input logic m);
    @(negedge Clock); Enter = 1'b1; Input = x;
    @(negedge Clock); Enter = 1'b0;
    check("xload_state", State, 1);
    check("xload_halt", Halt, 0);
    check("xload_error", Error, 0);
    push_exp(x, y, m);
    @(negedge Clock); Enter = 1'b1; Input = y; Mode = m;
    @(negedge Clock); Enter = 1'b0;
    check("yload_state", State, 2);
  endtask

  task automatic wait_halt();
    int n = 0;
    st_log.delete();
    st_log.push_back(int'(State));
    while (!Halt && n < 2000) begin
      @(negedge Clock);
      st_log.push_back(int'(State));
      n++;
    end
    if (!Halt) check("halt_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic m);
    do_load(x, y, m);
    wait_halt();
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic m);
    int n = 0;
    @(negedge Clock); e16 = 1'b1; in16 = x;
    @(negedge Clock); e16 = 1'b0;
    @(negedge Clock); e16 = 1'b1; in16 = y; m16 = m;
    @(negedge Clock); e16 = 1'b0;
    while (!h16 && n < 4000) begin
      @(negedge Clock);
      n++;
    end
    if (!h16) check("w16_timeout", 0, 1);
    check("w16_output", out16, gcd_model(x, y));
    check("w16_error", err16, 0);
    check("w16_state", st16, 6);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_seq[7] = '{2, 3, 3, 3, 3, 3, 6};
    logic [7:0] rx, ry;
    logic       rm;

    repeat (3) @(posedge Clock);
    @(negedge Clock); Reset = 1'b0;
    check("rst_output", Output, 0);
    check("rst_halt", Halt, 0);
    check("rst_error", Error, 0);
    check("rst_state", State, 0);
    check("rst_cycles", Cycles, 0);

    // Hand-computed anchors for the model itself.
    check("model_gcd_48_18", gcd_model(48, 18), 6);
    check("model_sub_48_18", sub_cycles(48, 18), 5);
    check("model_stein_48_18", stein_cycles(48, 18), 7);
    check("model_sub_127_1", sub_cycles(127, 1), 127);
    check("model_gcd_0_35", gcd_model(0, 35), 35);

    // Subtractive 48,18 with state trace.
    check("idle_before_x", State, 0);
    do_op(8'd48, 8'd18, 1'b0);
    check("sub48_seq_len", st_log.size(), 7);
    for (int i = 0; i < 7 && i < st_log.size(); i++) check("sub48_seq", st_log[i], exp_seq[i]);
    check("sub48_output", Output, 6);
    check("sub48_cycles", Cycles, 5);

    // Stein 48,18.
    do_op(8'd48, 8'd18, 1'b1);
    check("stein48_output", Output, 6);
    check("stein48_cycles", Cycles, 7);
    check("stein48_k", dut.k_q, 1);

    // Boundaries.
    do_op(8'd127, 8'd1, 1'b0);
    check("b127_output", Output, 1);
    check("b127_cycles", Cycles, 127);
    do_op(8'd255, 8'd255, 1'b0);
    check("b255_output", Output, 255);
    check("b255_cycles", Cycles, 1);

    // Zero handling: CHECK then DONE on the next edge.
    do_op(8'd0, 8'd35, 1'b0);
    check("z35_seq_len", st_log.size(), 2);
    check("z35_output", Output, 35);
    check("z35_error", Error, 0);
    check("z35_cycles", Cycles, 0);
    do_op(8'd0, 8'd0, 1'b1);
    check("z00_output", Output, 0);
    check("z00_error", Error, 1);

    // Enter held high: one load of X=77, Input changes ignored.
    @(negedge Clock); Enter = 1'b1; Input = 8'd77;
    @(negedge Clock); Input = 8'd50;
    check("hold_halt_drop", Halt, 0);
    check("hold_err_clear", Error, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_state", State, 1);
      @(negedge Clock);
    end
    Enter = 1'b0;
    push_exp(77, 7, 1'b0);
    @(negedge Clock); Enter = 1'b1; Input = 8'd7; Mode = 1'b0;
    @(negedge Clock); Enter = 1'b0;
    wait_halt();
    check("hold_output", Output, 7);
    check("hold_cycles", Cycles, 11);

    // Reset mid-SUB.
    do_load(8'd127, 8'd1, 1'b0);
    repeat (10) @(negedge Clock);
    check("pre_rst_state", State, 3);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_output", Output, 0);
    check("mid_rst_halt", Halt, 0);
    check("mid_rst_error", Error, 0);
    check("mid_rst_state", State, 0);
    check("mid_rst_cycles", Cycles, 0);
    exp_q.delete(); exp_cyc_q.delete(); exp_err_q.delete();
    Reset = 1'b0;

    // Random regression.
    for (int i = 0; i < 100; i++) begin
      rx = 8'($urandom_range(1, 255));
      ry = 8'($urandom_range(1, 255));
      rm = 1'($urandom_range(0, 1));
      do_op(rx, ry, rm);
    end

    // Wide instance: counter saturation and random Stein.
    op16(16'd1000, 16'd1, 1'b0);
    check("w16_sat_cycles", cyc16, 15);
    for (int i = 0; i < 5; i++)
      op16(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), 1'b1);

    @(negedge Clock);
    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
